decode_queue_unit: RTL and testbench
====================================

// Module: decode_queue_unit
// PURPOSE
//  Parametrised successor to the NeonFox instruction decoder. Places a QUEUE_DEPTH-entry prefetch queue between the
//  program cache and the decode registers, so a fetch can continue while the decode stage is stalled by a hazard.
//  Decodes the 16-bit ISA into registered control outputs for the regfile, ALU, memory/IO port and PC unit.
//  Adds flush on redirect and a dec_valid qualifier, and makes every output deterministic.
// PARAMETERS
//  QUEUE_DEPTH   4        queue entries; power of 2, >=2
//  NOP_WORD      16'hC000 word injected into I_reg on empty queue or flush
//  DATA_PORT     5'h18    regfile address of data-memory port
//  IO_PORT       5'h19    regfile address of IO port
//  STATUS_REG    5'h1E    regfile address of status register
// PORTS
//  clk            in   1   clock
//  rst            in   1   synchronous active-high reset
//  prg_data       in   16  instruction word from program cache
//  prg_valid      in   1   prg_data valid this cycle (low during p-cache miss)
//  fetch_ready    out  1   queue can accept a word (count < QUEUE_DEPTH), combinational
//  hazard         in   1   decode stall: I_reg and all decoded outputs hold
//  flush          in   1   PC redirect: discard queued and in-flight instructions
//  queue_ovf      out  1   sticky; prg_valid seen while fetch_ready low
//  dec_valid      out  1   decoded outputs come from a real instruction (not an injected NOP)
//  I_field out 10, H_en out 1, L_en out 1, src_raddr out 5, dest_waddr out 5, alu_op out 4, regf_wren out 1
//  data_wren/data_ren/IO_wren/IO_ren/status_ren/address_select/data_select/IO_select  out 1 each
//  pc_jmp/pc_brx/pc_brxt/pc_call/pc_ret  out 1 each
// BEHAVIOUR
//  Reset: queue empty; I_reg=NOP_WORD; all 1-bit outputs 0; alu_op=ALU_NOP; I_field/src/dest 0; fetch_ready=1.
//  Push: on prg_valid & fetch_ready, write prg_data at the tail. A word offered while full is dropped and sets queue_ovf.
//  Pop: on ~hazard, I_reg <= head and the head is popped. If the queue is empty, I_reg <= NOP_WORD and no pop occurs.
//  Push and pop in the same cycle leave the count unchanged. Pointers wrap modulo QUEUE_DEPTH.
//  Decode: on ~hazard, outputs <= decode(I_reg) and dec_valid <= I_reg-was-popped. On hazard, all outputs hold.
//  Latency: prg_valid word -> outputs after 3 clk edges with an empty queue and no hazard.
//  Flush: priority over push/pop in the same cycle.
//   - Queue emptied; the flush-cycle push is discarded.
//   - I_reg <= NOP_WORD; the decode registers load the NOP decode (dec_valid=0).
//   - Flush applies even while hazard is high.
//  Decode table, opcode I[15:12]:
//   - 0-A ALU ops (ADD,ADDC,SUB,SUBC,MOVE,NOT,ROR,ROL,AND,XOR,OR), using the alu_op encodings in the package.
//     regf_wren=1; dest=I[4:0].
//     data_wren=(dest==DATA_PORT); IO_wren=(dest==IO_PORT).
//     data_ren/IO_ren/status_ren: src I[9:5] compared against the same addresses.
//     address_select=dest in {1A,1B}; data_select=dest in {14,15}; IO_select=(dest==16).
//   - B control: dest=5'h11; regf_wren=|I[11:10]; pc_jmp=I[8]; pc_call=~I[8]&~I[9]; pc_ret=~I[8]&I[9].
//   - C brx=|I[11:10]; this is NOP when I[11:10]=0.
//   - D brx=1.
//   - E lim: dest={3'b100,I[9:8]}; regf_wren=1.
//   - F bitt: alu_op=BITT; only the read strobes (data_ren/IO_ren/status_ren) are decoded.
//   - Always: I_field=I[9:0]; H_en=I[11]; L_en=I[10]; src=I[9:5]; pc_brxt=I[12].
//   - Non-writing ops drive dest=0. All unlisted strobes are 0.
//  Reset mid-operation: same as the Reset line above; queue_ovf clears.
// CONFIGURATION
//  DECODE_QUEUE_BYPASS_EN
//   - Defined: when the queue is empty, ~hazard, and a push occurs, prg_data loads I_reg directly without being enqueued.
//     Latency drops to 2 edges.
//   - Undefined: every word passes through the queue; latency is 3 edges.
// STRUCTURE
//  neonfox_pkg holds the ALU_* op constants, an opcode enum (OP_ADD..OP_BITT), the NOP_WORD default,
//  special regfile addresses (DATA_PORT, IO_PORT, STATUS_REG, AUX1=5'h11) and a decoded-control struct.
//  Sub-module instr_queue(QUEUE_DEPTH): sync FIFO with push/pop/flush, count, full, empty.
//  Decode is a function in the package.
// TESTING
//  1 Reset, then stream 0x0318 (ADD to DATA_PORT) -> 3 edges later: data_wren=1, regf_wren=1, alu_op=0, dest=18, dec_valid=1.
//  2 Hold hazard 6 cycles while pushing 5 words, DEPTH=4 -> fetch_ready low after 4 words, queue_ovf=1, outputs hold.
//    Release hazard -> the 4 stored words drain in order.
//  3 flush with 3 words queued, hazard=1 -> next cycle queue empty, dec_valid=0, pc_* = 0; the next word pushed decodes normally.
//  4 Opcode sweep: 0xB100 -> pc_jmp=1; 0xB000 -> pc_call=1; 0xB200 -> pc_ret=1; 0xBC00 -> regf_wren=1 with dest=11;
//    0xC000 -> brx=0; 0xD000 -> brx=1, brxt=1; 0xE3FF -> dest=13, wren=1.
//  5 0xF300 (bitt, src 18) -> data_ren=1, data_wren=0, regf_wren=0, alu_op=F.
//  6 With DECODE_QUEUE_BYPASS_EN on an empty queue -> outputs valid 2 edges after prg_valid; 3 edges without it.

Source files
------------

// File: rtl/decode_queue_unit_pkg.sv
// NeonFox decode package: ALU codes, opcodes, regfile addresses,
// decoded-control bundle and the instruction decode function.
package neonfox_pkg;

  // ALU codes for 0-A equal the opcode, so ALU ops pass I[15:12] through
  localparam logic [3:0] ALU_ADD  = 4'h0;
  localparam logic [3:0] ALU_ADDC = 4'h1;
  localparam logic [3:0] ALU_SUB  = 4'h2;
  localparam logic [3:0] ALU_SUBC = 4'h3;
  localparam logic [3:0] ALU_MOVE = 4'h4;
  localparam logic [3:0] ALU_NOT  = 4'h5;
  localparam logic [3:0] ALU_ROR  = 4'h6;
  localparam logic [3:0] ALU_ROL  = 4'h7;
  localparam logic [3:0] ALU_AND  = 4'h8;
  localparam logic [3:0] ALU_XOR  = 4'h9;
  localparam logic [3:0] ALU_OR   = 4'hA;
  localparam logic [3:0] ALU_NOP  = 4'hB;
  localparam logic [3:0] ALU_BITT = 4'hF;

  typedef enum logic [3:0] {
    OP_ADD, OP_ADDC, OP_SUB, OP_SUBC,
    OP_MOVE, OP_NOT, OP_ROR, OP_ROL,
    OP_AND, OP_XOR, OP_OR, OP_CTRL,
    OP_BRX, OP_BRXA, OP_LIM, OP_BITT
  } opcode_e;

  localparam logic [15:0] NOP_WORD_DFLT   = 16'hC000;
  localparam logic [4:0]  DATA_PORT_ADDR  = 5'h18;
  localparam logic [4:0]  IO_PORT_ADDR    = 5'h19;
  localparam logic [4:0]  STATUS_REG_ADDR = 5'h1E;
  localparam logic [4:0]  AUX1_ADDR       = 5'h11;

  typedef struct packed {
    logic [9:0] i_field;
    logic       h_en;
    logic       l_en;
    logic [4:0] src;
    logic [4:0] dest;
    logic [3:0] alu_op;
    logic       regf_wren;
    logic       data_wren;
    logic       data_ren;
    logic       io_wren;
    logic       io_ren;
    logic       status_ren;
    logic       address_select;
    logic       data_select;
    logic       io_select;
    logic       pc_jmp;
    logic       pc_brx;
    logic       pc_brxt;
    logic       pc_call;
    logic       pc_ret;
  } ctrl_t;

  localparam ctrl_t CTRL_RST = '{alu_op: ALU_NOP, default: '0};

  function automatic ctrl_t decode(
    input logic [15:0] i,
    input logic [4:0]  dp,
    input logic [4:0]  iop,
    input logic [4:0]  sr
  );
    ctrl_t      c;
    opcode_e    op;
    logic [4:0] s;
    logic [4:0] d;
    c = CTRL_RST;
    op = opcode_e'(i[15:12]);
    s = i[9:5];
    d = i[4:0];
    c.i_field = i[9:0];
    c.h_en    = i[11];
    c.l_en    = i[10];
    c.src     = s;
    c.pc_brxt = i[12];
    unique case (1'b1)
      (op <= OP_OR): begin
        c.alu_op         = i[15:12];
        c.regf_wren      = 1'b1;
        c.dest           = d;
        c.data_wren      = (d == dp);
        c.io_wren        = (d == iop);
        c.data_ren       = (s == dp);
        c.io_ren         = (s == iop);
        c.status_ren     = (s == sr);
        c.address_select = (d == 5'h1A) || (d == 5'h1B);
        c.data_select    = (d == 5'h14) || (d == 5'h15);
        c.io_select      = (d == 5'h16);
      end
      (op == OP_CTRL): begin
        c.regf_wren = |i[11:10];
        c.dest      = c.regf_wren ? AUX1_ADDR : 5'h00;
        c.pc_jmp    = i[8];
        c.pc_call   = ~i[8] & ~i[9];
        c.pc_ret    = ~i[8] & i[9];
      end
      (op == OP_BRX): c.pc_brx = |i[11:10];
      (op == OP_BRXA): c.pc_brx = 1'b1;
      (op == OP_LIM): begin
        c.dest      = {3'b100, i[9:8]};
        c.regf_wren = 1'b1;
      end
      (op == OP_BITT): begin
        c.alu_op     = ALU_BITT;
        c.data_ren   = (s == dp);
        c.io_ren     = (s == iop);
        c.status_ren = (s == sr);
      end
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/decode_queue_unit_instr_queue.sv
// Prefetch FIFO between program cache and decode.
// Flush empties it; pointers wrap at DEPTH (power of 2).
module instr_queue
  import neonfox_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [15:0]   wdata,
  output logic [15:0]   rdata,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [15:0]   mem_q [DEPTH];
  logic [15:0]   mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (push) begin
        mem_d[wr_q] = wdata;
        wr_d = wr_q + AW'(1);
      end
      if (pop) rd_d = rd_q + AW'(1);
      cnt_d = cnt_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '{default: '0};
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  assign rdata = mem_q[rd_q];
  assign count = cnt_q;
  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);

endmodule

// File: rtl/decode_queue_unit.sv
// NeonFox decoder with prefetch queue, flush and dec_valid.
// DECODE_QUEUE_BYPASS_EN: empty-queue words load I_reg directly.
module decode_queue_unit
  import neonfox_pkg::*;
#(
  parameter int unsigned QUEUE_DEPTH = 4,
  parameter logic [15:0] NOP_WORD    = NOP_WORD_DFLT,
  parameter logic [4:0]  DATA_PORT   = DATA_PORT_ADDR,
  parameter logic [4:0]  IO_PORT     = IO_PORT_ADDR,
  parameter logic [4:0]  STATUS_REG  = STATUS_REG_ADDR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] prg_data,
  input  logic        prg_valid,
  output logic        fetch_ready,
  input  logic        hazard,
  input  logic        flush,
  output logic        queue_ovf,
  output logic        dec_valid,
  output logic [9:0]  I_field,
  output logic        H_en,
  output logic        L_en,
  output logic [4:0]  src_raddr,
  output logic [4:0]  dest_waddr,
  output logic [3:0]  alu_op,
  output logic        regf_wren,
  output logic        data_wren,
  output logic        data_ren,
  output logic        IO_wren,
  output logic        IO_ren,
  output logic        status_ren,
  output logic        address_select,
  output logic        data_select,
  output logic        IO_select,
  output logic        pc_jmp,
  output logic        pc_brx,
  output logic        pc_brxt,
  output logic        pc_call,
  output logic        pc_ret
);

  localparam int unsigned CW = $clog2(QUEUE_DEPTH) + 1;

  logic          q_push, q_pop, q_full, q_empty;
  logic [15:0]   q_rdata;
  logic [CW-1:0] q_count;
  logic          accept, byp;

  logic [15:0] ireg_q, ireg_d;
  logic        ireg_v_q, ireg_v_d;
  ctrl_t       ctrl_q, ctrl_d;
  logic        dv_q, dv_d;
  logic        ovf_q, ovf_d;

  assign fetch_ready = (q_count != CW'(QUEUE_DEPTH));
  assign accept = prg_valid & fetch_ready & ~flush;

`ifdef DECODE_QUEUE_BYPASS_EN
  assign byp = accept & q_empty & ~hazard;
`else
  assign byp = 1'b0;
`endif

  assign q_push = accept & ~q_full & ~byp;
  assign q_pop  = ~hazard & ~q_empty & ~flush;

  instr_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (q_push),
    .pop   (q_pop),
    .flush (flush),
    .wdata (prg_data),
    .rdata (q_rdata),
    .count (q_count),
    .full  (q_full),
    .empty (q_empty)
  );

  always_comb begin
    ireg_d   = ireg_q;
    ireg_v_d = ireg_v_q;
    ctrl_d   = ctrl_q;
    dv_d     = dv_q;
    ovf_d    = ovf_q | (prg_valid & ~fetch_ready);
    if (flush) begin
      ireg_d   = NOP_WORD;
      ireg_v_d = 1'b0;
      ctrl_d   = decode(NOP_WORD, DATA_PORT, IO_PORT, STATUS_REG);
      dv_d     = 1'b0;
    end else if (!hazard) begin
      ctrl_d = decode(ireg_q, DATA_PORT, IO_PORT, STATUS_REG);
      dv_d   = ireg_v_q;
      if (byp) begin
        ireg_d   = prg_data;
        ireg_v_d = 1'b1;
      end else if (!q_empty) begin
        ireg_d   = q_rdata;
        ireg_v_d = 1'b1;
      end else begin
        ireg_d   = NOP_WORD;
        ireg_v_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ireg_q   <= NOP_WORD;
      ireg_v_q <= 1'b0;
      ctrl_q   <= CTRL_RST;
      dv_q     <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      ireg_q   <= ireg_d;
      ireg_v_q <= ireg_v_d;
      ctrl_q   <= ctrl_d;
      dv_q     <= dv_d;
      ovf_q    <= ovf_d;
    end
  end

  assign queue_ovf      = ovf_q;
  assign dec_valid      = dv_q;
  assign I_field        = ctrl_q.i_field;
  assign H_en           = ctrl_q.h_en;
  assign L_en           = ctrl_q.l_en;
  assign src_raddr      = ctrl_q.src;
  assign dest_waddr     = ctrl_q.dest;
  assign alu_op         = ctrl_q.alu_op;
  assign regf_wren      = ctrl_q.regf_wren;
  assign data_wren      = ctrl_q.data_wren;
  assign data_ren       = ctrl_q.data_ren;
  assign IO_wren        = ctrl_q.io_wren;
  assign IO_ren         = ctrl_q.io_ren;
  assign status_ren     = ctrl_q.status_ren;
  assign address_select = ctrl_q.address_select;
  assign data_select    = ctrl_q.data_select;
  assign IO_select      = ctrl_q.io_select;
  assign pc_jmp         = ctrl_q.pc_jmp;
  assign pc_brx         = ctrl_q.pc_brx;
  assign pc_brxt        = ctrl_q.pc_brxt;
  assign pc_call        = ctrl_q.pc_call;
  assign pc_ret         = ctrl_q.pc_ret;

endmodule

// File: tb/tb_decode_queue_unit.sv
// Scoreboard bench for decode_queue_unit: queue-level model
// predicts each output update; a monitor pops and compares.
module tb_decode_queue_unit;
  import neonfox_pkg::*;

  localparam int DEPTH = 4;
  localparam logic [15:0] NOP = 16'hC000;
  localparam logic [4:0] DPORT = 5'h18;
  localparam logic [4:0] IPORT = 5'h19;
  localparam logic [4:0] SREG  = 5'h1E;
`ifdef DECODE_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
  localparam int LAT = 2;
`else
  localparam bit BYP = 1'b0;
  localparam int LAT = 3;
`endif
  localparam logic [40:0] RST_VEC =
    {1'b0, 10'd0, 1'b0, 1'b0, 5'd0, 5'd0, ALU_NOP, 14'd0};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [15:0] prg_data = '0;
  logic prg_valid = 1'b0;
  logic hazard = 1'b0;
  logic flush = 1'b0;
  logic fetch_ready, queue_ovf, dec_valid;
  logic [9:0] I_field;
  logic H_en, L_en;
  logic [4:0] src_raddr, dest_waddr;
  logic [3:0] alu_op;
  logic regf_wren, data_wren, data_ren, IO_wren, IO_ren;
  logic status_ren, address_select, data_select, IO_select;
  logic pc_jmp, pc_brx, pc_brxt, pc_call, pc_ret;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  decode_queue_unit #(.QUEUE_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .prg_data(prg_data),
    .prg_valid(prg_valid), .fetch_ready(fetch_ready),
    .hazard(hazard), .flush(flush), .queue_ovf(queue_ovf),
    .dec_valid(dec_valid), .I_field(I_field), .H_en(H_en),
    .L_en(L_en), .src_raddr(src_raddr),
    .dest_waddr(dest_waddr), .alu_op(alu_op),
    .regf_wren(regf_wren), .data_wren(data_wren),
    .data_ren(data_ren), .IO_wren(IO_wren), .IO_ren(IO_ren),
    .status_ren(status_ren), .address_select(address_select),
    .data_select(data_select), .IO_select(IO_select),
    .pc_jmp(pc_jmp), .pc_brx(pc_brx), .pc_brxt(pc_brxt),
    .pc_call(pc_call), .pc_ret(pc_ret)
  );

  logic [40:0] dut_vec;
  assign dut_vec = {dec_valid, I_field, H_en, L_en, src_raddr,
    dest_waddr, alu_op, regf_wren, data_wren, data_ren,
    IO_wren, IO_ren, status_ren, address_select, data_select,
    IO_select, pc_jmp, pc_brx, pc_brxt, pc_call, pc_ret};

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference decode straight from the opcode table
  function automatic logic [40:0] ref_dec(input logic [15:0] w,
                                          input bit v);
    logic [3:0] alu_tab [16] = '{ALU_ADD, ALU_ADDC, ALU_SUB,
      ALU_SUBC, ALU_MOVE, ALU_NOT, ALU_ROR, ALU_ROL, ALU_AND,
      ALU_XOR, ALU_OR, ALU_NOP, ALU_NOP, ALU_NOP, ALU_NOP, ALU_NOP};
    logic [3:0] op = w[15:12];
    logic [4:0] s = w[9:5];
    logic [4:0] d = 5'd0;
    logic [3:0] alu = ALU_NOP;
    logic wr = 0, dw = 0, dr = 0, iw = 0, ir = 0, sr = 0;
    logic as = 0, ds = 0, is = 0, j = 0, bx = 0, cl = 0, rt = 0;
    bit rds = 0;
    if (op <= 4'hA) begin
      alu = alu_tab[op];
      d = w[4:0];
      wr = 1;
      dw = (d == DPORT);
      iw = (d == IPORT);
      as = (d == 5'h1A || d == 5'h1B);
      ds = (d == 5'h14 || d == 5'h15);
      is = (d == 5'h16);
      rds = 1;
    end else begin
      case (op)
        4'hB: begin
          wr = (w[11:10] != 2'b00);
          if (wr) d = 5'h11;
          j = w[8];
          cl = !w[8] && !w[9];
          rt = !w[8] && w[9];
        end
        4'hC: bx = (w[11:10] != 2'b00);
        4'hD: bx = 1;
        4'hE: begin d = {3'b100, w[9:8]}; wr = 1; end
        default: begin alu = ALU_BITT; rds = 1; end
      endcase
    end
    if (rds) begin
      dr = (s == DPORT);
      ir = (s == IPORT);
      sr = (s == SREG);
    end
    return {v, w[9:0], w[11], w[10], s, d, alu, wr, dw, dr, iw, ir,
            sr, as, ds, is, j, bx, w[12], cl, rt};
  endfunction

  logic [15:0] mq[$];
  logic [15:0] m_ireg = NOP;
  bit m_iv = 0;
  bit m_ovf = 0;
  logic [40:0] exp_q[$];

  task automatic model_edge();
    int sz;
    bit acc;
    if (rst) begin
      mq.delete();
      m_ireg = NOP;
      m_iv = 0;
      m_ovf = 0;
      return;
    end
    sz = mq.size();
    if (prg_valid && sz >= DEPTH) m_ovf = 1;
    if (flush) begin
      mq.delete();
      m_ireg = NOP;
      m_iv = 0;
      exp_q.push_back(ref_dec(NOP, 0));
      return;
    end
    acc = prg_valid && sz < DEPTH;
    if (!hazard) begin
      exp_q.push_back(ref_dec(m_ireg, m_iv));
      if (BYP && sz == 0 && acc) begin
        m_ireg = prg_data;
        m_iv = 1;
        acc = 0;
      end else if (sz > 0) begin
        m_ireg = mq.pop_front();
        m_iv = 1;
      end else begin
        m_ireg = NOP;
        m_iv = 0;
      end
    end
    if (acc) mq.push_back(prg_data);
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("fetch_ready", 64'(fetch_ready), 64'(mq.size() < DEPTH));
    check("queue_ovf", 64'(queue_ovf), 64'(m_ovf));
  endtask

  logic mon_h, mon_f, mon_r;
  logic [40:0] last_exp = RST_VEC;

  always @(posedge clk) begin
    mon_h = hazard;
    mon_f = flush;
    mon_r = rst;
    #1;
    if (mon_r) begin
      last_exp = RST_VEC;
    end else if (mon_f || !mon_h) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL decode_out: got 0x%0h, expected none", dut_vec);
      end else begin
        last_exp = exp_q.pop_front();
        check("decode_out", 64'(dut_vec), 64'(last_exp));
      end
    end else begin
      check("hold", 64'(dut_vec), 64'(last_exp));
    end
  end

  task automatic push_word(input logic [15:0] w);
    prg_valid = 1'b1;
    prg_data = w;
    cyc();
    prg_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  logic [15:0] sweep [8] = '{16'hB100, 16'hB000, 16'hB200,
    16'hBC00, 16'hC000, 16'hD000, 16'hE3FF, 16'hF300};

  initial begin
    idle(2);
    rst = 1'b0;
    check("reset_outputs", 64'(dut_vec), 64'(RST_VEC));
    check("reset_ready", 64'(fetch_ready), 64'd1);

    // first-word latency through the queue (or bypass)
    prg_valid = 1'b1;
    prg_data = 16'h0318;
    for (int k = 1; k <= LAT; k++) begin
      cyc();
      prg_valid = 1'b0;
      if (k == LAT - 1) check("latency_early", 64'(dec_valid), 64'd0);
    end
    check("lat_dec_valid", 64'(dec_valid), 64'd1);
    check("lat_data_wren", 64'(data_wren), 64'd1);
    check("lat_regf_wren", 64'(regf_wren), 64'd1);
    check("lat_alu_op", 64'(alu_op), 64'h0);
    check("lat_dest", 64'(dest_waddr), 64'h18);
    idle(3);

    // overflow under hazard, then drain in order
    hazard = 1'b1;
    for (int i = 0; i < 5; i++) push_word(16'h0100 + 16'(i * 33));
    cyc();
    check("ovf_ready_low", 64'(fetch_ready), 64'd0);
    check("ovf_sticky", 64'(queue_ovf), 64'd1);
    hazard = 1'b0;
    idle(6);

    // flush under hazard with three words queued
    hazard = 1'b1;
    for (int i = 0; i < 3; i++) push_word(16'h1234 + 16'(i));
    flush = 1'b1;
    prg_valid = 1'b1;
    prg_data = 16'h0318;
    cyc();
    flush = 1'b0;
    prg_valid = 1'b0;
    check("flush_dec_valid", 64'(dec_valid), 64'd0);
    check("flush_pc", 64'({pc_jmp, pc_brx, pc_brxt, pc_call, pc_ret}),
          64'd0);
    check("flush_empty", 64'(fetch_ready), 64'd1);
    hazard = 1'b0;
    push_word(16'hD000);
    idle(4);

    // opcode sweep, back to back
    for (int i = 0; i < 8; i++) push_word(sweep[i]);
    idle(5);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      prg_valid = 1'($urandom_range(0, 1));
      prg_data = 16'($urandom);
      hazard = ($urandom_range(0, 9) < 3);
      flush = ($urandom_range(0, 49) == 0);
      cyc();
    end
    prg_valid = 1'b0;
    hazard = 1'b0;
    flush = 1'b0;

    // reset in the middle of traffic clears queue_ovf
    hazard = 1'b1;
    for (int i = 0; i < 5; i++) push_word(16'($urandom));
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    hazard = 1'b0;
    check("midrst_outputs", 64'(dut_vec), 64'(RST_VEC));
    for (int i = 0; i < 200; i++) begin
      prg_valid = 1'($urandom_range(0, 1));
      prg_data = 16'($urandom);
      hazard = ($urandom_range(0, 9) < 4);
      cyc();
    end
    prg_valid = 1'b0;
    hazard = 1'b0;
    idle(DEPTH + 4);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
